// File: rtl/ysyx_22041461_lsu.sv
// ysyx_22041461_lsu: load/store unit in the execute stage.
// It takes the ALU effective address and store data and performs one data-memory
// access over a valid/ready bus. The result and destination tag go to writeback
// through a second valid/ready handshake. One access is in flight at a time.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             execute-stage request (mem_op, addr, wdata, rd)
//   mem_req_*         bus request (aligned address, write enable/strobe/data)
//   mem_rvalid/rdata  bus read data or write acknowledge (one-cycle pulse)
//   resp_*            writeback response (extended load data, rd tag, error)
module ysyx_22041461_lsu #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [7:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            r_state;
  logic [3:0]        r_op;
  logic [2:0]        r_off;
  logic              r_req_ready;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_wen;
  logic [7:0]        r_mem_wstrb;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [4:0]        r_resp_rd;
  logic              r_resp_err;

  logic              w_misalign;
  logic              w_err;
  logic [7:0]        w_size_mask;
  logic [7:0]        w_strb;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_ext;

  // Request-side decode, evaluated on the incoming (not yet latched) request.
  always_comb begin
    w_misalign  = 1'b0;
    w_size_mask = 8'h00;
    unique case (mem_op[1:0])
      2'd0: begin w_misalign = 1'b0;               w_size_mask = 8'h01; end
      2'd1: begin w_misalign = addr[0];            w_size_mask = 8'h03; end
      2'd2: begin w_misalign = (addr[1:0] != 2'd0); w_size_mask = 8'h0F; end
      2'd3: begin w_misalign = (addr[2:0] != 3'd0); w_size_mask = 8'hFF; end
      default: ;
    endcase
    // Reserved op, unsigned store, or misaligned access.
    w_err = (mem_op[2:0] == 3'b111) || (mem_op[3] && mem_op[2]) || w_misalign;
    w_strb     = w_size_mask << addr[2:0];
    w_wdata_sh = wdata << {addr[2:0], 3'b000};
  end

  // Load extraction from the raw doubleword, using the latched op and offset.
  always_comb begin
    w_raw = mem_rdata >> {r_off, 3'b000};
    w_ext = w_raw;
    unique case (r_op[2:0])
      3'b000:  w_ext = {{56{w_raw[7]}},  w_raw[7:0]};
      3'b001:  w_ext = {{48{w_raw[15]}}, w_raw[15:0]};
      3'b010:  w_ext = {{32{w_raw[31]}}, w_raw[31:0]};
      3'b011:  w_ext = w_raw;
      3'b100:  w_ext = {56'd0, w_raw[7:0]};
      3'b101:  w_ext = {48'd0, w_raw[15:0]};
      3'b110:  w_ext = {32'd0, w_raw[31:0]};
      default: w_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_op            <= 4'd0;
      r_off           <= 3'd0;
      r_req_ready     <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wen       <= 1'b0;
      r_mem_wstrb     <= 8'h00;
      r_mem_wdata     <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_rd       <= 5'd0;
      r_resp_err      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_op        <= mem_op;
            r_off       <= addr[2:0];
            r_resp_rd   <= rd;
            r_req_ready <= 1'b0;
            if (w_err) begin
              // Errors skip the bus entirely and respond next cycle.
              r_state      <= StResp;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state         <= StReq;
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= {addr[ADDR_W-1:3], 3'b000};
              r_mem_wen       <= mem_op[3];
              r_mem_wstrb     <= mem_op[3] ? w_strb : 8'h00;
              r_mem_wdata     <= mem_op[3] ? w_wdata_sh : '0;
              r_resp_err      <= 1'b0;
            end
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            r_state         <= StWait;
            r_mem_req_valid <= 1'b0;
          end
        end
        StWait: begin
          if (mem_rvalid) begin
            r_state      <= StResp;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_op[3] ? '0 : w_ext;
          end
        end
        StResp: begin
          if (resp_ready) begin
            r_state      <= StIdle;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_wen       = r_mem_wen;
  assign mem_wstrb     = r_mem_wstrb;
  assign mem_wdata     = r_mem_wdata;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_rd       = r_resp_rd;
  assign resp_err      = r_resp_err;

endmodule
